// File: rtl/vga_pattern_data.sv
// Test-pattern pixel source: white, colour bars, checkerboard and an optional bouncing square.
// Define VGA_PATTERN_BOUNCE_EN to build in the mode-3 bouncing-square logic.
module vga_pattern_data #(
    parameter int unsigned H_VALID   = 640,
    parameter int unsigned V_VALID   = 480,
    parameter int unsigned BAR_NUM   = 8,
    parameter int unsigned CHK_SHIFT = 5,
    parameter int unsigned SQ_SIZE   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [1:0]  mode_sel,
    input  logic        mode_req,
    output logic [15:0] pix_data,
    output logic [1:0]  mode_cur,
    output logic        mode_ack,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned PIX_W  = 10;
    localparam int unsigned EXT_W  = PIX_W + 1;
    localparam int unsigned PROD_W = 2 * PIX_W;
    localparam int unsigned RGB_W  = 16;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic [PIX_W-1:0] PIX_BLANK = '1;
    localparam logic [EXT_W-1:0] H_LIM     = EXT_W'(H_VALID);
    localparam logic [EXT_W-1:0] V_LIM     = EXT_W'(V_VALID);
    localparam logic [PIX_W-1:0] H_LAST    = PIX_W'(H_VALID - 1);
    localparam logic [PIX_W-1:0] V_LAST    = PIX_W'(V_VALID - 1);

    localparam logic [MODE_W-1:0] MODE_WHITE   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_BARS    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_CHECKER = 2'd2;
    localparam logic [MODE_W-1:0] MODE_SQUARE  = 2'd3;

    localparam logic [RGB_W-1:0] RGB_WHITE = 16'hFFFF;
    localparam logic [RGB_W-1:0] RGB_BLACK = 16'h0000;
    localparam logic [RGB_W-1:0] RGB_RED   = 16'hF800;
    localparam logic [RGB_W-1:0] RGB_BLUE  = 16'h001F;

    // Reject parameter sets the fixed 10-bit coordinate datapath cannot represent.
    if (BAR_NUM < 1 || BAR_NUM > H_VALID || H_VALID > 1023 || V_VALID > 1023 ||
        SQ_SIZE >= H_VALID || SQ_SIZE >= V_VALID || CHK_SHIFT >= PIX_W) begin : g_bad_cfg
        $error("vga_pattern_data: unsupported parameter set");
    end

    logic [RGB_W-1:0]  pix_data_q,   pix_data_d;
    logic [MODE_W-1:0] mode_cur_q,   mode_cur_d;
    logic              mode_ack_q,   mode_ack_d;
    logic [CNT_W-1:0]  frame_cnt_q,  frame_cnt_d;
    logic              pend_valid_q, pend_valid_d;
    logic [MODE_W-1:0] pend_mode_q,  pend_mode_d;

    logic             frame_end_c;
    logic             req_ok_c;
    logic             pix_ok_c;
    logic [2:0]       bar_idx_c;
    logic             chk_c;
    logic             sq_inside_c;

    function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    assign frame_end_c = (pix_x == H_LAST) && (pix_y == V_LAST);

`ifdef VGA_PATTERN_BOUNCE_EN
    assign req_ok_c = mode_req;
`else
    // Without the square logic a mode-3 request is dropped before it reaches the pending register.
    assign req_ok_c = mode_req && (mode_sel != MODE_SQUARE);
`endif

    assign pix_ok_c  = (pix_x != PIX_BLANK) && (pix_y != PIX_BLANK) &&
                       ({1'b0, pix_x} < H_LIM) && ({1'b0, pix_y} < V_LIM);
    assign bar_idx_c = 3'((PROD_W'(pix_x) * PROD_W'(BAR_NUM)) / PROD_W'(H_VALID));
    assign chk_c     = 1'((pix_x >> CHK_SHIFT) ^ (pix_y >> CHK_SHIFT));

`ifdef VGA_PATTERN_BOUNCE_EN
    localparam logic [PIX_W-1:0] SQ_X_MAX = PIX_W'(H_VALID - SQ_SIZE);
    localparam logic [PIX_W-1:0] SQ_Y_MAX = PIX_W'(V_VALID - SQ_SIZE);
    localparam logic [EXT_W-1:0] SQ_EDGE  = EXT_W'(SQ_SIZE);

    logic [PIX_W-1:0] sq_x_q, sq_x_d;
    logic [PIX_W-1:0] sq_y_q, sq_y_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;

    // Square steps one pixel per axis per frame; at a wall it spends that frame turning around.
    always_comb begin : square_next
        sq_x_d  = sq_x_q;
        sq_y_d  = sq_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (frame_end_c) begin
            if (dir_x_q) begin
                if (sq_x_q == SQ_X_MAX) dir_x_d = 1'b0;
                else                    sq_x_d  = sq_x_q + 10'd1;
            end else begin
                if (sq_x_q == '0)       dir_x_d = 1'b1;
                else                    sq_x_d  = sq_x_q - 10'd1;
            end
            if (dir_y_q) begin
                if (sq_y_q == SQ_Y_MAX) dir_y_d = 1'b0;
                else                    sq_y_d  = sq_y_q + 10'd1;
            end else begin
                if (sq_y_q == '0)       dir_y_d = 1'b1;
                else                    sq_y_d  = sq_y_q - 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : square_regs
        if (!rst_n) begin
            sq_x_q  <= '0;
            sq_y_q  <= '0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else begin
            sq_x_q  <= sq_x_d;
            sq_y_q  <= sq_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign sq_inside_c = ({1'b0, pix_x} >= {1'b0, sq_x_q}) &&
                         ({1'b0, pix_x} <  ({1'b0, sq_x_q} + SQ_EDGE)) &&
                         ({1'b0, pix_y} >= {1'b0, sq_y_q}) &&
                         ({1'b0, pix_y} <  ({1'b0, sq_y_q} + SQ_EDGE));
`else
    assign sq_inside_c = 1'b0;
`endif

    // Mode requests are parked until frame end; a request on the frame-end cycle itself wins.
    always_comb begin : mode_next
        pend_valid_d = pend_valid_q;
        pend_mode_d  = pend_mode_q;
        mode_cur_d   = mode_cur_q;
        mode_ack_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        if (req_ok_c) begin
            pend_valid_d = 1'b1;
            pend_mode_d  = mode_sel;
        end
        if (frame_end_c) begin
            frame_cnt_d  = frame_cnt_q + 8'd1;
            pend_valid_d = 1'b0;
            if (req_ok_c || pend_valid_q) begin
                mode_cur_d = req_ok_c ? mode_sel : pend_mode_q;
                mode_ack_d = 1'b1;
            end
        end
    end

    always_comb begin : pixel_mux
        pix_data_d = RGB_BLACK;
        if (pix_ok_c) begin
            case (mode_cur_q)
                MODE_WHITE:   pix_data_d = RGB_WHITE;
                MODE_BARS:    pix_data_d = bar_color(bar_idx_c);
                MODE_CHECKER: pix_data_d = chk_c ? RGB_WHITE : RGB_BLACK;
                MODE_SQUARE:  pix_data_d = sq_inside_c ? RGB_RED : RGB_BLUE;
                default:      pix_data_d = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : main_regs
        if (!rst_n) begin
            pix_data_q   <= '0;
            mode_cur_q   <= MODE_WHITE;
            mode_ack_q   <= 1'b0;
            frame_cnt_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_mode_q  <= '0;
        end else begin
            pix_data_q   <= pix_data_d;
            mode_cur_q   <= mode_cur_d;
            mode_ack_q   <= mode_ack_d;
            frame_cnt_q  <= frame_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_mode_q  <= pend_mode_d;
        end
    end

    assign pix_data  = pix_data_q;
    assign mode_cur  = mode_cur_q;
    assign mode_ack  = mode_ack_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_data.sv
// Directed self-checking bench for vga_pattern_data at default parameters.
module tb_vga_pattern_data;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [1:0]  mode_sel;
    logic        mode_req;
    logic [15:0] pix_data;
    logic [1:0]  mode_cur;
    logic        mode_ack;
    logic [7:0]  frame_cnt;

    int n_vec;
    int n_err;
    int exp_frames;

    vga_pattern_data dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .mode_sel  (mode_sel),
        .mode_req  (mode_req),
        .pix_data  (pix_data),
        .mode_cur  (mode_cur),
        .mode_ack  (mode_ack),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns one cycle later with the registered response visible.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic req, input logic [1:0] sel);
        pix_x    = x;
        pix_y    = y;
        mode_req = req;
        mode_sel = sel;
        @(negedge clk);
        mode_req = 1'b0;
    endtask

    task automatic frame_end(input logic req, input logic [1:0] sel);
        step(10'd639, 10'd479, req, sel);
        exp_frames++;
    endtask

    // Position after n frame ends for a 0..m bounce that pauses one frame at each wall.
    function automatic int bounce_pos(input int n, input int m);
        int p;
        p = n % (2 * m + 2);
        return (p <= m) ? p : (2 * m + 1 - p);
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_vec++; if (pix_data !== 16'h0000) begin n_err++; $display("FAIL reset_pix: got %h want %h", pix_data, 16'h0000); end
        n_vec++; if (mode_cur !== 2'd0) begin n_err++; $display("FAIL reset_mode: got %0d want %0d", mode_cur, 0); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want %b", mode_ack, 1'b0); end
        n_vec++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL reset_fcnt: got %0d want %0d", frame_cnt, 0); end
        rst_n = 1'b1;
        exp_frames = 0;
    endtask

    task automatic test_white;
        step(10'd100, 10'd100, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hFFFF) begin n_err++; $display("FAIL white_100_100: got %h want %h", pix_data, 16'hFFFF); end
        step(10'h3ff, 10'd100, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'h0000) begin n_err++; $display("FAIL white_blank_x: got %h want %h", pix_data, 16'h0000); end
        step(10'd640, 10'd100, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'h0000) begin n_err++; $display("FAIL white_x640: got %h want %h", pix_data, 16'h0000); end
        step(10'd100, 10'd480, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'h0000) begin n_err++; $display("FAIL white_y480: got %h want %h", pix_data, 16'h0000); end
        step(10'd639, 10'd478, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hFFFF) begin n_err++; $display("FAIL white_edge: got %h want %h", pix_data, 16'hFFFF); end
    endtask

    task automatic test_bars;
        step(10'd0, 10'd0, 1'b1, 2'd1);
        n_vec++; if (pix_data !== 16'hFFFF) begin n_err++; $display("FAIL bars_pre_pix: got %h want %h", pix_data, 16'hFFFF); end
        n_vec++; if (mode_cur !== 2'd0) begin n_err++; $display("FAIL bars_pre_mode: got %0d want %0d", mode_cur, 0); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL bars_pre_ack: got %b want %b", mode_ack, 1'b0); end
        frame_end(1'b0, 2'd0);
        n_vec++; if (mode_cur !== 2'd1) begin n_err++; $display("FAIL bars_mode: got %0d want %0d", mode_cur, 1); end
        n_vec++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL bars_ack: got %b want %b", mode_ack, 1'b1); end
        n_vec++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL bars_fcnt: got %0d want %0d", frame_cnt, 1); end
        step(10'd0, 10'd0, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hFFFF) begin n_err++; $display("FAIL bars_x0: got %h want %h", pix_data, 16'hFFFF); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL bars_ack_once: got %b want %b", mode_ack, 1'b0); end
        step(10'd80, 10'd0, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hFFE0) begin n_err++; $display("FAIL bars_x80: got %h want %h", pix_data, 16'hFFE0); end
        step(10'd639, 10'd0, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'h0000) begin n_err++; $display("FAIL bars_x639: got %h want %h", pix_data, 16'h0000); end
        step(10'd160, 10'd10, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'h07FF) begin n_err++; $display("FAIL bars_x160: got %h want %h", pix_data, 16'h07FF); end
        step(10'd400, 10'd10, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hF800) begin n_err++; $display("FAIL bars_x400: got %h want %h", pix_data, 16'hF800); end
        step(10'd480, 10'd10, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'h001F) begin n_err++; $display("FAIL bars_x480: got %h want %h", pix_data, 16'h001F); end
    endtask

    task automatic test_checker;
        step(10'd5, 10'd5, 1'b1, 2'd2);
        frame_end(1'b0, 2'd0);
        n_vec++; if (mode_cur !== 2'd2) begin n_err++; $display("FAIL chk_mode: got %0d want %0d", mode_cur, 2); end
        n_vec++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL chk_ack: got %b want %b", mode_ack, 1'b1); end
        step(10'd0, 10'd0, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'h0000) begin n_err++; $display("FAIL chk_0_0: got %h want %h", pix_data, 16'h0000); end
        step(10'd32, 10'd0, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hFFFF) begin n_err++; $display("FAIL chk_32_0: got %h want %h", pix_data, 16'hFFFF); end
        step(10'd32, 10'd32, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'h0000) begin n_err++; $display("FAIL chk_32_32: got %h want %h", pix_data, 16'h0000); end
        step(10'd31, 10'd32, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hFFFF) begin n_err++; $display("FAIL chk_31_32: got %h want %h", pix_data, 16'hFFFF); end
        step(10'd640, 10'd32, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'h0000) begin n_err++; $display("FAIL chk_x640: got %h want %h", pix_data, 16'h0000); end
    endtask

    task automatic test_last_wins;
        step(10'd1, 10'd1, 1'b1, 2'd1);
        step(10'd2, 10'd1, 1'b1, 2'd0);
        frame_end(1'b0, 2'd0);
        n_vec++; if (mode_cur !== 2'd0) begin n_err++; $display("FAIL last_wins_a_mode: got %0d want %0d", mode_cur, 0); end
        n_vec++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL last_wins_a_ack: got %b want %b", mode_ack, 1'b1); end
        step(10'd1, 10'd1, 1'b1, 2'd1);
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL last_wins_a_single: got %b want %b", mode_ack, 1'b0); end
        step(10'd2, 10'd1, 1'b1, 2'd2);
        frame_end(1'b0, 2'd0);
        n_vec++; if (mode_cur !== 2'd2) begin n_err++; $display("FAIL last_wins_b_mode: got %0d want %0d", mode_cur, 2); end
        n_vec++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL last_wins_b_ack: got %b want %b", mode_ack, 1'b1); end
        step(10'd100, 10'd0, 1'b0, 2'd0);
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL last_wins_b_single: got %b want %b", mode_ack, 1'b0); end
        n_vec++; if (pix_data !== 16'hFFFF) begin n_err++; $display("FAIL last_wins_b_pix: got %h want %h", pix_data, 16'hFFFF); end
    endtask

    task automatic test_coincident;
        frame_end(1'b1, 2'd1);
        n_vec++; if (mode_cur !== 2'd1) begin n_err++; $display("FAIL coinc_mode: got %0d want %0d", mode_cur, 1); end
        n_vec++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL coinc_ack: got %b want %b", mode_ack, 1'b1); end
        step(10'd80, 10'd0, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hFFE0) begin n_err++; $display("FAIL coinc_pix: got %h want %h", pix_data, 16'hFFE0); end
    endtask

    task automatic test_no_pending;
        frame_end(1'b0, 2'd0);
        n_vec++; if (mode_cur !== 2'd1) begin n_err++; $display("FAIL nopend_mode: got %0d want %0d", mode_cur, 1); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL nopend_ack: got %b want %b", mode_ack, 1'b0); end
        n_vec++; if (frame_cnt !== 8'(exp_frames)) begin n_err++; $display("FAIL nopend_fcnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

`ifdef VGA_PATTERN_BOUNCE_EN
    task automatic test_mode3;
        int sx;
        int sy;
        frame_end(1'b1, 2'd3);
        n_vec++; if (mode_cur !== 2'd3) begin n_err++; $display("FAIL sq_mode: got %0d want %0d", mode_cur, 3); end
        n_vec++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL sq_ack: got %b want %b", mode_ack, 1'b1); end
        for (int k = 0; k < 3; k++) begin
            while (exp_frames < 608 + k) frame_end(1'b0, 2'd0);
            sx = bounce_pos(exp_frames, 608);
            sy = bounce_pos(exp_frames, 448);
            step(10'(sx), 10'(sy), 1'b0, 2'd0);
            n_vec++; if (pix_data !== 16'hF800) begin n_err++; $display("FAIL sq_corner_f%0d: got %h want %h", exp_frames, pix_data, 16'hF800); end
            step(10'(sx - 1), 10'(sy), 1'b0, 2'd0);
            n_vec++; if (pix_data !== 16'h001F) begin n_err++; $display("FAIL sq_left_f%0d: got %h want %h", exp_frames, pix_data, 16'h001F); end
            step(10'(sx + 31), 10'(sy + 31), 1'b0, 2'd0);
            n_vec++; if (pix_data !== 16'hF800) begin n_err++; $display("FAIL sq_far_f%0d: got %h want %h", exp_frames, pix_data, 16'hF800); end
            step(10'(sx), 10'(sy + 32), 1'b0, 2'd0);
            n_vec++; if (pix_data !== 16'h001F) begin n_err++; $display("FAIL sq_below_f%0d: got %h want %h", exp_frames, pix_data, 16'h001F); end
        end
    endtask
`else
    task automatic test_mode3;
        step(10'd1, 10'd1, 1'b1, 2'd2);
        step(10'd2, 10'd1, 1'b1, 2'd3);
        frame_end(1'b0, 2'd0);
        n_vec++; if (mode_cur !== 2'd2) begin n_err++; $display("FAIL nosq_keep_mode: got %0d want %0d", mode_cur, 2); end
        n_vec++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL nosq_keep_ack: got %b want %b", mode_ack, 1'b1); end
        frame_end(1'b1, 2'd3);
        n_vec++; if (mode_cur !== 2'd2) begin n_err++; $display("FAIL nosq_mode: got %0d want %0d", mode_cur, 2); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL nosq_ack: got %b want %b", mode_ack, 1'b0); end
        step(10'd100, 10'd0, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hFFFF) begin n_err++; $display("FAIL nosq_pix: got %h want %h", pix_data, 16'hFFFF); end
    endtask
`endif

    task automatic test_frame_cnt;
        n_vec++; if (frame_cnt !== 8'(exp_frames)) begin n_err++; $display("FAIL fcnt_now: got %0d want %0d", frame_cnt, exp_frames % 256); end
        while (exp_frames % 256 != 255) frame_end(1'b0, 2'd0);
        n_vec++; if (frame_cnt !== 8'd255) begin n_err++; $display("FAIL fcnt_255: got %0d want %0d", frame_cnt, 255); end
        frame_end(1'b0, 2'd0);
        n_vec++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL fcnt_wrap: got %0d want %0d", frame_cnt, 0); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL fcnt_no_ack: got %b want %b", mode_ack, 1'b0); end
        frame_end(1'b0, 2'd0);
        n_vec++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL fcnt_after_wrap: got %0d want %0d", frame_cnt, 1); end
    endtask

    task automatic test_reset_mid;
        step(10'd100, 10'd0, 1'b1, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (pix_data !== 16'h0000) begin n_err++; $display("FAIL rstmid_pix: got %h want %h", pix_data, 16'h0000); end
        n_vec++; if (mode_cur !== 2'd0) begin n_err++; $display("FAIL rstmid_mode: got %0d want %0d", mode_cur, 0); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_ack: got %b want %b", mode_ack, 1'b0); end
        n_vec++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL rstmid_fcnt: got %0d want %0d", frame_cnt, 0); end
        exp_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(10'd100, 10'd100, 1'b0, 2'd0);
        n_vec++; if (pix_data !== 16'hFFFF) begin n_err++; $display("FAIL rstmid_white: got %h want %h", pix_data, 16'hFFFF); end
        frame_end(1'b0, 2'd0);
        n_vec++; if (mode_cur !== 2'd0) begin n_err++; $display("FAIL rstmid_no_pend_mode: got %0d want %0d", mode_cur, 0); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_no_pend_ack: got %b want %b", mode_ack, 1'b0); end
        n_vec++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL rstmid_fcnt_after: got %0d want %0d", frame_cnt, 1); end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        exp_frames = 0;
        rst_n      = 1'b0;
        pix_x      = 10'd0;
        pix_y      = 10'd0;
        mode_sel   = 2'd0;
        mode_req   = 1'b0;
        test_reset;
        test_white;
        test_bars;
        test_checker;
        test_last_wins;
        test_coincident;
        test_no_pending;
        test_mode3;
        test_frame_cnt;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_pattern_data.md
VGA_PATTERN_DATA -- requirements
Module: vga_pattern_data

Interface
REQ-001 SHALL have parameter H_VALID, default 640: active pixels per line.
REQ-002 SHALL have parameter V_VALID, default 480: active lines per frame.
REQ-003 SHALL have parameter BAR_NUM, default 8: colour-bar count, 1..H_VALID.
REQ-004 SHALL have parameter CHK_SHIFT, default 5: checker cell edge = 2^CHK_SHIFT pixels.
REQ-005 SHALL have parameter SQ_SIZE, default 32: bouncing-square edge in pixels, < min(H_VALID, V_VALID).
REQ-006 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port pix_x, input, 10: current column; 10'h3ff = blanking.
REQ-009 SHALL have port pix_y, input, 10: current row; 10'h3ff = blanking.
REQ-010 SHALL have port mode_sel, input, 2: requested pattern (0 white, 1 bars, 2 checker, 3 square).
REQ-011 SHALL have port mode_req, input, 1: one-cycle strobe qualifying mode_sel.
REQ-012 SHALL have port pix_data, output, 16: RGB565 pixel, registered.
REQ-013 SHALL have port mode_cur, output, 2: pattern in effect.
REQ-014 SHALL have port mode_ack, output, 1: one-cycle pulse when a requested mode takes effect.
REQ-015 SHALL have port frame_cnt, output, 8: completed-frame counter, wraps 255->0.

Function
REQ-016 pix_data SHALL have exactly one cycle of latency from pix_x/pix_y.
REQ-017 pix_data SHALL be 0 when pix_x or pix_y = 10'h3ff, or when pix_x >= H_VALID or pix_y >= V_VALID.
REQ-018 Mode 0 SHALL output 16'hFFFF.
REQ-019 Mode 1 SHALL output palette[(pix_x*BAR_NUM/H_VALID) mod 8], palette = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-020 Mode 2 SHALL output FFFF when bit0 of ((pix_x>>CHK_SHIFT) XOR (pix_y>>CHK_SHIFT)) = 1, else 0000.
REQ-021 Mode 3 SHALL output F800 inside square [sq_x, sq_x+SQ_SIZE) x [sq_y, sq_y+SQ_SIZE), else 001F.
REQ-022 Frame end SHALL be the cycle with pix_x = H_VALID-1 and pix_y = V_VALID-1.
REQ-023 A mode_req SHALL latch mode_sel into a pending register; later requests before frame end overwrite it (last wins).
REQ-024 At frame end with a pending request, mode_cur SHALL take the pending value and mode_ack SHALL pulse high the following cycle.
REQ-025 A mode_req coinciding with frame end SHALL be applied at that same frame end.
REQ-026 No pending request at frame end SHALL leave mode_cur unchanged, with no mode_ack.
REQ-027 frame_cnt SHALL increment by 1 at every frame end, wrapping 255->0.
REQ-028 Square position SHALL step 1 pixel per axis at each frame end; direction reverses instead of stepping when at 0 (moving negative) or at H_VALID-SQ_SIZE / V_VALID-SQ_SIZE (moving positive).
REQ-029 Square position SHALL never leave [0, H_VALID-SQ_SIZE] x [0, V_VALID-SQ_SIZE].

Reset
REQ-030 On rst_n low SHALL force pix_data=0, mode_cur=0, mode_ack=0, frame_cnt=0, pending cleared, sq_x=sq_y=0, direction +x/+y, asynchronously.
REQ-031 Reset mid-frame SHALL discard any pending request; operation resumes in mode 0 at the next pixel after release.

Configuration
REQ-032 Macro VGA_PATTERN_BOUNCE_EN defined SHALL compile in the mode-3 square logic per REQ-021/028/029.
REQ-033 Without VGA_PATTERN_BOUNCE_EN, square registers SHALL be absent, mode 3 requests SHALL be ignored (no mode_ack, mode_cur unchanged), and all other behaviour SHALL be unchanged.

Verification
REQ-034 Reset, mode 0, pix=(100,100) -> pix_data=FFFF one cycle later; pix_x=3ff -> 0000; pix_x=640 -> 0000.
REQ-035 Mode 1 request, run to frame end; pix_x=0/80/639 -> FFFF/FFE0/0000; mode_ack pulses once after frame end.
REQ-036 Mode 2: (0,0)->0000, (32,0)->FFFF, (32,32)->0000.
REQ-037 mode_req sel=1 then sel=2 in same frame -> mode_cur=2 after frame end, single mode_ack; req coincident with frame end -> applied immediately.
REQ-038 With macro, mode 3, 608 frames: sq_x reaches 608, reverses, then decreases; 256 frame ends -> frame_cnt wraps to 0.
REQ-039 Without macro, mode 3 request -> mode_cur unchanged, no mode_ack; rst_n low mid-frame -> all outputs 0 immediately.
